// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : Shared types, counter widths and timing helper for the VGA
//             sync decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int GOOD_W = 3;

    // Lock-tracking state machine.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    // Derived timing: totals and first-visible counter positions.
    typedef struct packed {
        logic [HCNT_W-1:0] h_tot;
        logic [VCNT_W-1:0] v_tot;
        logic [HCNT_W-1:0] h_act;
        logic [VCNT_W-1:0] v_act;
    } timing_t;

    function automatic timing_t calc_timing(
        input int h_sync,
        input int h_back,
        input int h_disp,
        input int h_front,
        input int v_sync,
        input int v_back,
        input int v_disp,
        input int v_front
    );
        timing_t t;
        t.h_tot = HCNT_W'(h_sync + h_back + h_disp + h_front);
        t.v_tot = VCNT_W'(v_sync + v_back + v_disp + v_front);
        t.h_act = HCNT_W'(h_sync + h_back);
        t.v_act = VCNT_W'(v_sync + v_back);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : vga_edge_detect
//  Brief    : Two-flop synchronizer plus delay flop; flags a falling edge of
//             an asynchronous sync input.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchronize the input, then keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= sync_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    // Flops reset low, so an input that is already high never fakes an edge.
    assign fall_o = dly_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_decoder
//  Brief    : Recovers pixel coordinates from VGA hsync/vsync, measures line
//             and frame lengths and tracks lock against the nominal timing.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_DISP      = 640,
    parameter int H_FRONT     = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_DISP      = 480,
    parameter int V_FRONT     = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hSync,
    input  logic        vSync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        lineStart,
    output logic        frameStart,
    output logic        locked,
    output logic        err,
    output logic [10:0] hTotal,
    output logic [9:0]  vTotal
);

    localparam timing_t c_TIMING = calc_timing(H_SYNC, H_BACK, H_DISP, H_FRONT,
                                               V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam logic [HCNT_W-1:0] c_H_TOT = c_TIMING.h_tot;
    localparam logic [VCNT_W-1:0] c_V_TOT = c_TIMING.v_tot;
    localparam logic [HCNT_W-1:0] c_H_ACT = c_TIMING.h_act;
    localparam logic [VCNT_W-1:0] c_V_ACT = c_TIMING.v_act;
    localparam logic [HCNT_W-1:0] c_H_END = c_TIMING.h_act + HCNT_W'(H_DISP);
    localparam logic [VCNT_W-1:0] c_V_END = c_TIMING.v_act + VCNT_W'(V_DISP);
    localparam logic [HCNT_W-1:0] c_H_MAX = '1;
    localparam logic [VCNT_W-1:0] c_V_MAX = '1;
    localparam logic [GOOD_W-1:0] c_LOCK  = GOOD_W'(LOCK_FRAMES);

    logic w_hFall;
    logic w_vFall;

    logic [HCNT_W-1:0] hCount_q, hCount_d;
    logic [VCNT_W-1:0] vCount_q, vCount_d;
    logic [HCNT_W-1:0] hTotal_q;
    logic [VCNT_W-1:0] vTotal_q;
    logic              lineStart_q;
    logic              frameStart_q;

    sync_state_e       state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              frameBad_q, frameBad_d;
    logic              hSeen_q, hSeen_d;
    logic              err_q, err_d;

    logic [HCNT_W-1:0] w_hInc;
    logic [VCNT_W-1:0] w_vInc;
    logic [GOOD_W-1:0] w_goodInc;
    logic              w_badLine;
    logic              w_vBad;
    logic              w_hSatHit;
    logic              w_lockFail;
    logic              w_inWindow;

    vga_edge_detect u_hsync_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (hSync),
        .fall_o (w_hFall)
    );

    vga_edge_detect u_vsync_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (vSync),
        .fall_o (w_vFall)
    );

    assign w_hInc    = hCount_q + 1'b1;
    assign w_vInc    = vCount_q + 1'b1;
    assign w_goodInc = good_q + 1'b1;
    assign w_badLine = w_hFall & hSeen_q & (w_hInc != c_H_TOT);
    assign w_vBad    = (w_vInc != c_V_TOT);
    // Fires on the edge that moves hCount onto its saturation value.
    assign w_hSatHit = ~w_hFall & (hCount_q == c_H_MAX - 1'b1);
    assign w_lockFail = w_badLine | (w_vFall & w_vBad) | w_hSatHit;

    // Saturating pixel/line counters; vsync edge wins over hsync edge.
    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (w_hFall) begin
            hCount_d = '0;
        end else if (hCount_q != c_H_MAX) begin
            hCount_d = w_hInc;
        end
        if (w_vFall) begin
            vCount_d = '0;
        end else if (w_hFall && (vCount_q != c_V_MAX)) begin
            vCount_d = w_vInc;
        end
    end

    // Counter, measurement and edge-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            hTotal_q     <= '0;
            vTotal_q     <= '0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            lineStart_q  <= w_hFall;
            frameStart_q <= w_vFall;
            if (w_hFall) begin
                hTotal_q <= w_hInc;
            end
            if (w_vFall) begin
                vTotal_q <= w_vInc;
            end
        end
    end

    // Lock FSM state register together with its tracking flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            frameBad_q <= 1'b0;
            hSeen_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            frameBad_q <= frameBad_d;
            hSeen_q    <= hSeen_d;
            err_q      <= err_d;
        end
    end

    // Lock FSM next-state logic: qualify frames, count good ones, drop lock.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        frameBad_d = frameBad_q;
        hSeen_d    = hSeen_q;
        if (w_hFall) begin
            hSeen_d = 1'b1;
        end
        if (w_vFall) begin
            frameBad_d = 1'b0;
        end else if (w_badLine) begin
            frameBad_d = 1'b1;
        end
        case (state_q)
            SEARCH: begin
                if (w_vFall) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (w_hSatHit) begin
                    state_d = SEARCH;
                    hSeen_d = 1'b0;
                    good_d  = '0;
                end else if (w_vFall) begin
                    if (!frameBad_q && !w_badLine && !w_vBad) begin
                        good_d = w_goodInc;
                        if (w_goodInc == c_LOCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_lockFail) begin
                    state_d = SEARCH;
                    hSeen_d = 1'b0;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Lock FSM outputs: loss-of-lock pulse and the display window decode.
    always_comb begin
        err_d      = (state_q == LOCKED) & w_lockFail;
        w_inWindow = (hCount_q >= c_H_ACT) && (hCount_q < c_H_END) &&
                     (vCount_q >= c_V_ACT) && (vCount_q < c_V_END);
        active     = (state_q == LOCKED) && w_inWindow;
        x          = '0;
        y          = '0;
        if (active) begin
            x = 10'(hCount_q - c_H_ACT);
            y = 10'(vCount_q - c_V_ACT);
        end
    end

    assign locked     = (state_q == LOCKED);
    assign err        = err_q;
    assign lineStart  = lineStart_q;
    assign frameStart = frameStart_q;
    assign hTotal     = hTotal_q;
    assign vTotal     = vTotal_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

- Receive-side companion to the VGA timing generator.
- Samples `hSync`/`vSync` on the pixel clock and recovers pixel coordinates `x`/`y` plus a display-area flag.
- Measures line and frame lengths, and declares lock once the measured timing matches the parameters for a set number of frames.
- Drives the capture/overlay logic and the self-test path that loops generator output back into the FPGA.

## Interface
Parameters:
- `H_SYNC`, 96: hsync pulse length, pixel clocks
- `H_BACK`, 48: horizontal back porch
- `H_DISP`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `V_SYNC`, 2: vsync pulse length, lines
- `V_BACK`, 33: vertical back porch
- `V_DISP`, 480: visible lines
- `V_FRONT`, 10: vertical front porch
- `LOCK_FRAMES`, 2: consecutive good frames required for lock (1..7)

Ports:
- `clk`  in  1  pixel clock, one tick per pixel
- `reset`  in  1  asynchronous, active-high
- `hSync`  in  1  horizontal sync, active-low pulse, asynchronous to `clk`
- `vSync`  in  1  vertical sync, active-low pulse, asynchronous to `clk`
- `x`  out  10  pixel column, 0..H_DISP-1, 0 when not active
- `y`  out  10  pixel row, 0..V_DISP-1, 0 when not active
- `active`  out  1  inside the display window and locked
- `lineStart`  out  1  one-cycle pulse, hsync falling edge detected
- `frameStart`  out  1  one-cycle pulse, vsync falling edge detected
- `locked`  out  1  timing matches the parameters
- `err`  out  1  one-cycle pulse on loss of lock
- `hTotal`  out  11  last measured line length, clocks
- `vTotal`  out  10  last measured frame length, lines

## Operation
- **Constants:** H_TOT = sum of the H params (800); V_TOT = sum of the V params (525); H_ACT = H_SYNC+H_BACK; V_ACT = V_SYNC+V_BACK.
- **Input path:** each sync goes through a 2-flop synchronizer and then a delay flop. `hFall` = delayed high & synchronized low; `vFall` likewise.
- **hCount (11 bit):**
  - `hFall` → next value 0.
  - Otherwise increments, saturating at 2047.
  - On `hFall`, `hTotal` <= `hCount`+1.
- **vCount (10 bit):**
  - `vFall` → 0; `vFall` has priority when it coincides with `hFall`.
  - Otherwise `hFall` increments it, saturating at 1023.
  - On `vFall`, `vTotal` <= `vCount`+1.
- **Display window:** `active` = locked & H_ACT ≤ `hCount` < H_ACT+H_DISP & V_ACT ≤ `vCount` < V_ACT+V_DISP. When active, `x` = `hCount`−H_ACT and `y` = `vCount`−V_ACT; otherwise both are 0.
- **Line check:**
  - `hSeen` is set on the first `hFall` after reset or after entering SEARCH.
  - An `hFall` with `hSeen` already set and `hCount`+1 ≠ H_TOT is a bad line.
  - `frameBad` is a sticky flag set by any bad line.
- **FSM, state SEARCH:** on `vFall` → CHECK, with `good`=0 and `frameBad`=0.
- **FSM, state CHECK:**
  - On `vFall`, the frame is good if `frameBad` (including a bad line detected that same cycle) is 0 and `vCount`+1 = V_TOT.
  - Good frame: `good`++; when `good` reaches LOCK_FRAMES → LOCKED. Bad frame: `good`=0.
  - `frameBad` is cleared on every `vFall`.
- **FSM, state LOCKED:** any of the following → `err` pulse, then SEARCH:
  - a bad line;
  - `vFall` with `vCount`+1 ≠ V_TOT;
  - `hCount` reaching 2047 (hsync lost).
- **Saturation:** `hCount` saturation in CHECK → SEARCH without `err`.
- **Reset values:** all outputs 0; state SEARCH; counters, `hSeen`, `good` and `frameBad` all 0.

## Timing
- **Sync latency:** first `clk` edge that samples `hSync` low = edge k. `lineStart` is high in the cycle after edge k+2, the same cycle in which `hCount`=0. `vSync` → `frameStart`/`vCount`=0 has identical latency.
- **Outputs:** `lineStart`, `frameStart`, `err`, `locked`, `hTotal`, `vTotal` are registered. `x`, `y`, `active` are combinational from registered counters and state, so they are aligned with `hCount`.
- **Lock timing:** `locked` rises in the same cycle as the `frameStart` that completes the LOCK_FRAMES-th good frame. It falls in the same cycle as the `err` pulse.
- **Reset:** asynchronous; takes effect immediately mid-frame. Relock requires a full SEARCH → CHECK sequence.

## Structure
- Package `vga_timing_pkg` holds:
  - the FSM state enum (SEARCH, CHECK, LOCKED);
  - a function computing H_TOT/V_TOT/H_ACT/V_ACT from the parameters;
  - the counter width constants.
- Sub-module `vga_edge_detect`: 2-flop synchronizer + delay flop, falling-edge output. Instantiated once per sync input.

## Test plan
1. **Nominal lock:** nominal 640x480 sync from a bench model with ±0.3-clock jitter-free phase → `locked`=0 through frame starts 1–2, `locked`=1 at frame start 3, `hTotal`=800, `vTotal`=525.
2. **Active window:** once locked, at `hCount`=144, `vCount`=35 → `active`=1, `x`=0, `y`=0; at `hCount`=783, `vCount`=514 → `x`=639, `y`=479; at `hCount`=784 → `active`=0, `x`=0.
3. **Short line:** while locked, shorten one line to 799 clocks → `err` high exactly one cycle with that `lineStart`, `locked`=0, `hTotal`=799; relock after 3 more frame starts.
4. **Lost hsync:** while locked, hold `hSync` high → `err` pulse when `hCount` hits 2047, `locked`=0; `x`, `y`, `active` stay 0.
5. **Coincident edges:** drive `vSync` and `hSync` falling on the same clock → `lineStart` and `frameStart` pulse in the same cycle, `vCount`=0, no `err`.
6. **Mid-frame reset:** assert `reset` mid-frame for 3 cycles → all outputs 0 immediately; after release, `locked` returns only at the third subsequent `frameStart`.
